brl_wback: RTL and testbench
============================

BRL_WBACK -- requirements
Module: brl_wback

Interface
REQ-001 SHALL have port sys_clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1: the barrel-shifter stage presents a result this cycle.
REQ-004 SHALL have port in_ready, output, 1: the block can accept a result this cycle.
REQ-005 SHALL have port brlq, input, 32: shift/rotate result.
REQ-006 SHALL have port brl_carry, input, 1: carry out of the shifter.
REQ-007 SHALL have port dstwa, input, 6: destination register index, bank bit in [5].
REQ-008 SHALL have port flagld, input, 1: the accepted result updates the Z/N/C flags.
REQ-009 SHALL have port wr_req, output, 1: register-file write request.
REQ-010 SHALL have port wr_grant, input, 1: write port granted this cycle; external loads have priority.
REQ-011 SHALL have ports wr_addr (output, 6) and wr_data (output, 32): head-entry write address and data.
REQ-012 SHALL have ports fwd_valid (output, 1), fwd_addr (output, 6) and fwd_data (output, 32): youngest pending entry, used for operand bypass.
REQ-013 SHALL have ports zflag, nflag and cflag: outputs, 1 bit each, registered flags.
REQ-014 SHALL have ports flag_set (input, 1) and flag_d (input, 3): direct flag write, with {c,n,z} = flag_d[2:0].
REQ-015 SHALL have port flush, input, 1: synchronous discard of all pending entries.

Function
REQ-016 SHALL hold results in a 2-entry FIFO of {dstwa, brlq} with a count of 0..2.
REQ-017 SHALL drive in_ready = ~reset & (count < 2), combinational from registered state only.
REQ-018 SHALL push an entry on a rising edge when in_valid & in_ready & ~flush; in_valid without in_ready SHALL be ignored with no state change.
REQ-019 SHALL drive wr_req = (count != 0), with wr_addr/wr_data taken from the head entry; when count = 0, wr_addr and wr_data SHALL be 0.
REQ-020 SHALL pop the head entry on a rising edge when wr_req & wr_grant & ~flush.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; at count = 1 the new entry becomes the head in the following cycle.
REQ-022 Latency: a result accepted at edge N SHALL make wr_req = 1 from cycle N+1 when the FIFO was empty; with wr_grant held high it SHALL be written at edge N+1.
REQ-023 SHALL drive fwd_valid = (count != 0), with fwd_addr/fwd_data taken from the tail (youngest) entry; when both entries share an address, the youngest data SHALL be forwarded.
REQ-024 flush SHALL set count to 0 at the next edge, overriding any push or pop that cycle; flags SHALL be unaffected.
REQ-025 On an accepted push with flagld = 1, the flags SHALL update at that same edge: zflag = (brlq == 0), nflag = brlq[31], cflag = brl_carry.
REQ-026 flag_set SHALL load the flags from flag_d at the edge; if flag_set coincides with a flag-updating push, flag_set SHALL win.
REQ-027 A push refused because in_ready = 0 SHALL not update the flags.
REQ-028 A pushed entry SHALL never be lost or duplicated absent flush; FIFO pointers SHALL wrap modulo 2.

Reset
REQ-029 While reset is high: count = 0, both entries cleared to 0, wr_req = 0, wr_addr = 0, wr_data = 0, fwd_valid = 0, fwd_addr = 0, fwd_data = 0, zflag = nflag = cflag = 0, in_ready = 0.
REQ-030 Reset mid-operation SHALL discard pending entries; the first push after deassertion SHALL behave as with an empty FIFO.

Verification
REQ-031 Single result: push brlq = 0x00000000, brl_carry = 1, dstwa = 0x05, flagld = 1, wr_grant = 1 -> next cycle wr_req = 1, wr_addr = 0x05, wr_data = 0, z = 1, n = 0, c = 1; count = 0 after the following edge.
REQ-032 Backpressure: wr_grant = 0 with 3 consecutive pushes 0x11, 0x22, 0x33 -> in_ready = 0 after 2 pushes, 0x33 not accepted; raising wr_grant writes 0x11 then 0x22 in order.
REQ-033 Forwarding: push {0x03, 0xAAAA0000} then {0x03, 0x80000001} with wr_grant = 0 -> fwd_addr = 0x03, fwd_data = 0x80000001, wr_data = 0xAAAA0000, nflag = 1.
REQ-034 Flag priority: flag_set = 1 with flag_d = 3'b010 in the same cycle as a push of 0x00000000 with flagld = 1 -> z = 0, n = 1, c = 0.
REQ-035 Flush and reset: 2 entries pending, flush = 1 together with in_valid = 1 -> count = 0 and wr_req = 0 next cycle, no entry written; async reset mid-push -> all outputs 0 immediately.

Source files
------------

// File: rtl/brl_wback_if.sv
// brl_wback_if -- bus bundle between the barrel-shifter stage, the
// write-back buffer and the register file.
//
// Signals:
//   in_valid/in_ready        result handshake from the shifter stage
//   brlq, brl_carry          shift/rotate result and its carry out
//   dstwa                    destination register index (bank bit in [5])
//   flagld                   accepted result updates Z/N/C
//   wr_req/wr_grant          register-file write request / grant
//   wr_addr, wr_data         head entry being written
//   fwd_valid/addr/data      youngest pending entry for operand bypass
//   zflag, nflag, cflag      registered flags
//   flag_set, flag_d         direct flag load, {c,n,z} = flag_d
//   flush                    synchronous discard of pending entries
//
// Modports: master = shifter/register-file side, slave = write-back block.
interface brl_wback_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] brlq;
  logic        brl_carry;
  logic [5:0]  dstwa;
  logic        flagld;
  logic        wr_req;
  logic        wr_grant;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        fwd_valid;
  logic [5:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        zflag;
  logic        nflag;
  logic        cflag;
  logic        flag_set;
  logic [2:0]  flag_d;
  logic        flush;

  modport master (
    output in_valid, brlq, brl_carry, dstwa, flagld, wr_grant,
           flag_set, flag_d, flush,
    input  in_ready, wr_req, wr_addr, wr_data, fwd_valid, fwd_addr,
           fwd_data, zflag, nflag, cflag
  );

  modport slave (
    input  in_valid, brlq, brl_carry, dstwa, flagld, wr_grant,
           flag_set, flag_d, flush,
    output in_ready, wr_req, wr_addr, wr_data, fwd_valid, fwd_addr,
           fwd_data, zflag, nflag, cflag
  );
endinterface

// File: rtl/brl_wback.sv
// brl_wback -- write-back buffer for barrel-shifter results.
//
// Holds up to two {dstwa, brlq} results in a FIFO until the register-file
// write port is granted, forwards the youngest pending result for operand
// bypass, and maintains the Z/N/C flags.
//
// Ports:
//   sys_clk   single clock, rising edge
//   reset     asynchronous, active-high reset
//   bus       brl_wback_if.slave bundle (handshake, write port, bypass,
//             flags, flush)
module brl_wback (
  input  logic        sys_clk,
  input  logic        reset,
  brl_wback_if.slave  bus
);

  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [5:0]  addr_q [2];
  logic [31:0] data_q [2];
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        c_q, c_d;

  logic        in_ready;
  logic        nonempty;
  logic        tail_ptr;
  logic        push;
  logic        pop;

  assign in_ready = ~reset & (count_q < 2'd2);
  assign nonempty = (count_q != 2'd0);
  // Youngest entry sits one slot behind the write pointer.
  assign tail_ptr = ~wr_ptr_q;
  assign push     = bus.in_valid & in_ready & ~bus.flush;
  assign pop      = nonempty & bus.wr_grant & ~bus.flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Direct flag load beats a flag-updating push; refused or flushed
  // pushes never touch the flags.
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    c_d = c_q;
    if (bus.flag_set) begin
      {c_d, n_d, z_d} = bus.flag_d;
    end else if (push && bus.flagld) begin
      z_d = (bus.brlq == 32'd0);
      n_d = bus.brlq[31];
      c_d = bus.brl_carry;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      if (push) begin
        addr_q[wr_ptr_q] <= bus.dstwa;
        data_q[wr_ptr_q] <= bus.brlq;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.wr_req    = nonempty;
  assign bus.wr_addr   = nonempty ? addr_q[rd_ptr_q] : 6'd0;
  assign bus.wr_data   = nonempty ? data_q[rd_ptr_q] : 32'd0;
  assign bus.fwd_valid = nonempty;
  assign bus.fwd_addr  = nonempty ? addr_q[tail_ptr] : 6'd0;
  assign bus.fwd_data  = nonempty ? data_q[tail_ptr] : 32'd0;
  assign bus.zflag     = z_q;
  assign bus.nflag     = n_q;
  assign bus.cflag     = c_q;

endmodule

// File: tb/tb_brl_wback.sv
// tb_brl_wback -- directed, table-driven bench for brl_wback.
module tb_brl_wback;

  typedef struct {
    logic        iv;
    logic [31:0] brlq;
    logic        carry;
    logic [5:0]  dst;
    logic        fld;
    logic        gnt;
    logic        fset;
    logic [2:0]  fd;
    logic        fl;
    logic        e_rdy;
    logic        e_req;
    logic [5:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_fv;
    logic [5:0]  e_faddr;
    logic [31:0] e_fdata;
    logic [2:0]  e_cnz;
  } vec_t;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   errors  = 0;
  int   checks  = 0;
  vec_t vt [20];
  vec_t v;

  brl_wback_if bus ();

  brl_wback dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t x);
    chk({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, x.e_rdy});
    chk({tag, ".wr_req"},    {31'd0, bus.wr_req},    {31'd0, x.e_req});
    chk({tag, ".wr_addr"},   {26'd0, bus.wr_addr},   {26'd0, x.e_waddr});
    chk({tag, ".wr_data"},   bus.wr_data,            x.e_wdata);
    chk({tag, ".fwd_valid"}, {31'd0, bus.fwd_valid}, {31'd0, x.e_fv});
    chk({tag, ".fwd_addr"},  {26'd0, bus.fwd_addr},  {26'd0, x.e_faddr});
    chk({tag, ".fwd_data"},  bus.fwd_data,           x.e_fdata);
    chk({tag, ".cnz"},       {29'd0, bus.cflag, bus.nflag, bus.zflag}, {29'd0, x.e_cnz});
  endtask

  task automatic apply(input vec_t x);
    bus.in_valid  = x.iv;
    bus.brlq      = x.brlq;
    bus.brl_carry = x.carry;
    bus.dstwa     = x.dst;
    bus.flagld    = x.fld;
    bus.wr_grant  = x.gnt;
    bus.flag_set  = x.fset;
    bus.flag_d    = x.fd;
    bus.flush     = x.fl;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    //          iv  brlq          c   dst    fld gnt fs  fd      fl | rdy req waddr  wdata         fv  faddr  fdata         cnz
    vt[0]  = '{1'b1, 32'h00000000, 1'b1, 6'h05, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h05, 32'h00000000, 1'b1, 6'h05, 32'h00000000, 3'b101};
    vt[1]  = '{1'b0, 32'h00000000, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 6'h00, 32'h00000000, 1'b0, 6'h00, 32'h00000000, 3'b101};
    vt[2]  = '{1'b1, 32'h00000011, 1'b0, 6'h01, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h01, 32'h00000011, 1'b1, 6'h01, 32'h00000011, 3'b101};
    vt[3]  = '{1'b1, 32'h00000022, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 6'h01, 32'h00000011, 1'b1, 6'h02, 32'h00000022, 3'b101};
    vt[4]  = '{1'b1, 32'h00000033, 1'b0, 6'h03, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 6'h01, 32'h00000011, 1'b1, 6'h02, 32'h00000022, 3'b101};
    vt[5]  = '{1'b0, 32'h00000000, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h02, 32'h00000022, 1'b1, 6'h02, 32'h00000022, 3'b101};
    vt[6]  = '{1'b0, 32'h00000000, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 6'h00, 32'h00000000, 1'b0, 6'h00, 32'h00000000, 3'b101};
    vt[7]  = '{1'b1, 32'hAAAA0000, 1'b0, 6'h03, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h03, 32'hAAAA0000, 1'b1, 6'h03, 32'hAAAA0000, 3'b010};
    vt[8]  = '{1'b1, 32'h80000001, 1'b1, 6'h03, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 6'h03, 32'hAAAA0000, 1'b1, 6'h03, 32'h80000001, 3'b110};
    vt[9]  = '{1'b1, 32'h00000000, 1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 6'h00, 32'h00000000, 1'b0, 6'h00, 32'h00000000, 3'b110};
    vt[10] = '{1'b1, 32'h00000000, 1'b1, 6'h2A, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 6'h2A, 32'h00000000, 1'b1, 6'h2A, 32'h00000000, 3'b010};
    vt[11] = '{1'b1, 32'h12345678, 1'b0, 6'h3F, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h3F, 32'h12345678, 1'b1, 6'h3F, 32'h12345678, 3'b010};
    vt[12] = '{1'b1, 32'hFFFFFFFF, 1'b1, 6'h10, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 6'h00, 32'h00000000, 1'b0, 6'h00, 32'h00000000, 3'b010};
    vt[13] = '{1'b0, 32'h00000000, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 6'h00, 32'h00000000, 1'b0, 6'h00, 32'h00000000, 3'b101};
    vt[14] = '{1'b1, 32'hFFFFFFFF, 1'b0, 6'h20, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h20, 32'hFFFFFFFF, 1'b1, 6'h20, 32'hFFFFFFFF, 3'b010};
    vt[15] = '{1'b1, 32'h00000007, 1'b0, 6'h21, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 6'h20, 32'hFFFFFFFF, 1'b1, 6'h21, 32'h00000007, 3'b010};
    vt[16] = '{1'b1, 32'h00000099, 1'b1, 6'h11, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h21, 32'h00000007, 1'b1, 6'h21, 32'h00000007, 3'b010};
    vt[17] = '{1'b1, 32'h00000044, 1'b0, 6'h22, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 6'h21, 32'h00000007, 1'b1, 6'h22, 32'h00000044, 3'b010};
    vt[18] = '{1'b0, 32'h00000000, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h22, 32'h00000044, 1'b1, 6'h22, 32'h00000044, 3'b010};
    vt[19] = '{1'b0, 32'h00000000, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 6'h00, 32'h00000000, 1'b0, 6'h00, 32'h00000000, 3'b010};

    // Idle inputs; all expected outputs zero (reset state).
    v = '{1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 1'b0, 6'h0, 32'h0, 3'b000};
    apply(v);
    #1;
    chk_all("reset_hold", v);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      apply(vt[i]);
      step();
      chk_all($sformatf("vec%0d", i), vt[i]);
    end

    // Two entries pending, then async reset in the middle of a push.
    v = '{1'b1, 32'h80000000, 1'b1, 6'h30, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h30, 32'h80000000, 1'b1, 6'h30, 32'h80000000, 3'b110};
    apply(v);
    step();
    chk_all("pre_rst_a", v);
    v = '{1'b1, 32'h00000005, 1'b0, 6'h31, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 6'h30, 32'h80000000, 1'b1, 6'h31, 32'h00000005, 3'b110};
    apply(v);
    step();
    chk_all("pre_rst_b", v);
    v = '{1'b1, 32'h00000009, 1'b1, 6'h32, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 1'b0, 6'h0, 32'h0, 3'b000};
    apply(v);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", v);
    step();
    reset = 1'b0;

    // First push after reset behaves as into an empty FIFO.
    v = '{1'b1, 32'h00000010, 1'b0, 6'h07, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 6'h07, 32'h00000010, 1'b1, 6'h07, 32'h00000010, 3'b000};
    apply(v);
    step();
    chk_all("post_rst_push", v);
    v = '{1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 6'h0, 32'h0, 1'b0, 6'h0, 32'h0, 3'b000};
    apply(v);
    step();
    chk_all("post_rst_pop", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
